// File: rtl/pc_gen.sv
`default_nettype none
// ============================================================================
// pc_gen : fetch-stage next-PC selection with stall/backpressure hold and RAS
// Revision: 1.0
// ============================================================================
module pc_gen #(
    parameter int               XLEN         = 32,
    parameter logic [XLEN-1:0]  RESET_VECTOR = '0,
    parameter int               ALIGN_BITS   = 2,
    parameter int               RAS_DEPTH    = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_vector,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    input  logic            ras_push,
    input  logic [XLEN-1:0] ras_push_addr,
    input  logic            ras_pop,
    input  logic            fetch_ready,
    output logic            fetch_valid,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_previous,
    output logic            misaligned,
    output logic            ras_underflow
);

    localparam int              PTR_W      = $clog2(RAS_DEPTH);
    localparam int              CNT_W      = $clog2(RAS_DEPTH + 1);
    localparam logic [XLEN-1:0] PC_INC     = XLEN'(1) << ALIGN_BITS;
    localparam logic [XLEN-1:0] ALIGN_MASK = ~(PC_INC - XLEN'(1));
    localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(RAS_DEPTH);

    logic [XLEN-1:0]  pc_q, pc_d;
    logic [XLEN-1:0]  pc_prev_q, pc_prev_d;
    logic             fetch_valid_q;
    logic             misaligned_q, misaligned_d;
    logic             underflow_q, underflow_d;
    logic [PTR_W-1:0] top_q, top_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [XLEN-1:0]  ras_q [RAS_DEPTH];

    logic             accept;
    logic             ras_op;
    logic             ras_empty;
    logic             pop_hit;
    logic             take_target;
    logic [XLEN-1:0]  target_raw;
    logic             ras_wr_en;
    logic [PTR_W-1:0] ras_wr_idx;

    always_comb begin
        accept      = fetch_valid_q & fetch_ready & ~stall;
        take_target = trap_valid | redirect_valid;
        // RAS only moves with an accepted, non-redirected fetch
        ras_op      = accept & ~take_target;
        ras_empty   = (count_q == '0);
        pop_hit     = ras_op & ras_pop & ~ras_empty;
        target_raw  = trap_valid ? trap_vector : redirect_target;

        if (take_target)  pc_d = target_raw & ALIGN_MASK;
        else if (pop_hit) pc_d = ras_q[top_q];
        else if (accept)  pc_d = pc_q + PC_INC;
        else              pc_d = pc_q;

        pc_prev_d    = accept ? pc_q : pc_prev_q;
        misaligned_d = take_target & (|(target_raw & ~ALIGN_MASK));
        underflow_d  = ras_op & ras_pop & ras_empty;

        top_d      = top_q;
        count_d    = count_q;
        ras_wr_en  = 1'b0;
        ras_wr_idx = top_q;
        if (trap_valid) begin
            count_d = '0;
        end else if (ras_op) begin
            if (ras_push && pop_hit) begin
                // call+return in one slot: replace top in place, depth unchanged
                ras_wr_en = 1'b1;
            end else if (ras_push) begin
                ras_wr_en  = 1'b1;
                ras_wr_idx = top_q + PTR_W'(1);
                top_d      = top_q + PTR_W'(1);
                count_d    = (count_q == CNT_FULL) ? count_q : count_q + CNT_W'(1);
            end else if (pop_hit) begin
                top_d   = top_q - PTR_W'(1);
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q          <= RESET_VECTOR;
            pc_prev_q     <= '0;
            fetch_valid_q <= 1'b0;
            misaligned_q  <= 1'b0;
            underflow_q   <= 1'b0;
            top_q         <= '0;
            count_q       <= '0;
        end else begin
            pc_q          <= pc_d;
            pc_prev_q     <= pc_prev_d;
            fetch_valid_q <= 1'b1;
            misaligned_q  <= misaligned_d;
            underflow_q   <= underflow_d;
            top_q         <= top_d;
            count_q       <= count_d;
        end
    end

    // Entry contents are don't-care after reset; occupancy alone gates their use
    always_ff @(posedge clk) begin
        if (ras_wr_en) ras_q[ras_wr_idx] <= ras_push_addr;
    end

    assign fetch_valid   = fetch_valid_q;
    assign pc            = pc_q;
    assign pc_previous   = pc_prev_q;
    assign misaligned    = misaligned_q;
    assign ras_underflow = underflow_q;

endmodule
`default_nettype wire

// File: doc/pc_gen.md
# pc_gen

Parametrised program-counter generator for the fetch stage, the next generation of the current single-target PC register. It selects the next fetch address from trap, branch-redirect, return-address-stack and sequential sources by fixed priority. It holds the address under a stall or an instruction-memory backpressure handshake. It tracks the last accepted fetch address and keeps a small circular return-address stack (RAS) for call/return prediction.

## Interface
- XLEN, 32, address width in bits
- RESET_VECTOR, 0, PC value loaded on reset (XLEN bits)
- ALIGN_BITS, 2, low address bits that must be zero; the sequential increment is 2**ALIGN_BITS
- RAS_DEPTH, 4, return-address-stack entries, power of two, minimum 2

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- stall  in  1  hold PC (hazard unit)
- trap_valid  in  1  take trap, highest priority
- trap_vector  in  XLEN  trap target
- redirect_valid  in  1  branch/jump resolved, redirect
- redirect_target  in  XLEN  redirect target
- ras_push  in  1  decode saw a call
- ras_push_addr  in  XLEN  return address to push
- ras_pop  in  1  decode saw a return; predict from RAS top
- fetch_ready  in  1  instruction memory accepts the current address
- fetch_valid  out  1  pc is a valid fetch request
- pc  out  XLEN  current fetch address
- pc_previous  out  XLEN  address of last accepted fetch
- misaligned  out  1  one-cycle pulse: a redirect/trap target had nonzero low bits
- ras_underflow  out  1  one-cycle pulse: pop on empty RAS

## Operation
- Fetch acceptance: accept = fetch_valid & fetch_ready & ~stall.
- Next-PC priority, evaluated every cycle:
  1. trap_valid: trap_vector.
  2. redirect_valid: redirect_target.
  3. accept & ras_pop & RAS non-empty: RAS top.
  4. accept: pc + 2**ALIGN_BITS. Wraps modulo 2**XLEN with no error.
  5. Otherwise: hold pc.
- Trap and redirect apply even while stall=1 or fetch_ready=0. The in-flight fetch at the old pc is abandoned.
- Target alignment: the low ALIGN_BITS bits of the trap/redirect target are forced to zero. misaligned pulses if any of those bits were set.
- pc_previous loads the old pc on every accept, and also when a trap or redirect coincides with accept. It is otherwise unchanged.
- RAS is a circular buffer with a top pointer and an occupancy count 0..RAS_DEPTH. Push/pop take effect only on accept; trap/redirect ignore them.
  - Push: the entry at top+1 is written and becomes the new top. Count saturates at RAS_DEPTH, and a push when full overwrites the oldest entry.
  - Pop with count>0: the top is used as the next pc, then top and count are decremented.
  - Pop with count=0: ras_underflow pulses and the next pc is sequential.
  - Push and pop in the same accepted cycle: the next pc is the old top, the old top entry is replaced by ras_push_addr, and count is unchanged.
  - trap_valid clears count to 0. Redirect does not alter the RAS.
- Reset values: pc=RESET_VECTOR, pc_previous=0, fetch_valid=0, misaligned=0, ras_underflow=0, RAS count=0, top=0. RAS entry contents are don't-care.

## Timing
- All outputs are registered. The next-PC choice is visible on pc one cycle after the inputs are sampled.
- fetch_valid is 0 during reset. It rises on the first rising edge after rst_n deasserts and then stays 1.
- Sources 3–5 (RAS, sequential, hold) are not evaluated while fetch_valid=0. Trap and redirect are still honoured.
- misaligned and ras_underflow are high for exactly the cycle following the triggering edge.
- rst_n assertion mid-operation forces all reset values immediately (asynchronous) and discards pending RAS contents.
- Combinational path from fetch_ready to pc flops only; no combinational input-to-output path.

## Test plan
- Reset release with RESET_VECTOR=0x100, fetch_ready=1 -> fetch_valid=1 after one edge; pc sequence 0x100, 0x104, 0x108; pc_previous trails by one.
- fetch_ready=0 for 3 cycles, then stall=1 for 2 cycles -> pc holds 0x108 for 5 cycles; pc_previous constant.
- stall=1 with redirect_valid=1, target 0x2002 -> next pc=0x2000, misaligned pulses once; trap_valid with redirect in the same cycle, vector 0x80 -> pc=0x80.
- Push 0xA0, 0xB0, 0xC0, 0xD0, 0xE0 (DEPTH=4), then five pops -> pops return 0xE0, 0xD0, 0xC0, 0xB0; the fifth pop gives sequential pc and ras_underflow=1.
- Push and pop in the same cycle with top=0x40, push_addr=0x50 -> next pc=0x40; the following pop returns 0x50.
- pc=0xFFFFFFFC accepted -> pc wraps to 0x0; rst_n pulsed low mid-run with RAS non-empty -> pc=RESET_VECTOR, and a subsequent pop underflows.
